// File: rtl/demux1to2_buffered.sv
// -----------------------------------------------------------------------------
// demux1to2_buffered
//   Steers each word from one valid/ready input channel into one of two
//   output FIFOs, chosen per word by in_switch (0 -> out1, 1 -> out2).
//   Each output owns its own FIFO, so a stalled consumer never blocks
//   traffic headed to the other one. There is no combinational path from
//   the input to an output, and a full FIFO is never bypassed.
//
// Parameters
//   SIZE   data width of the input and both outputs
//   DEPTH  entries per output FIFO (power of two, >= 2)
//
// Ports
//   clk                    rising-edge clock
//   reset_n                asynchronous active-low reset, empties both FIFOs
//   in_data/in_switch      word and its destination select
//   in_valid/in_ready      input handshake; in_ready reflects the selected FIFO
//   outN_data/outN_valid   head word of FIFO N / FIFO N non-empty
//   outN_ready             consumer N accepts the head
//   outN_count             current occupancy of FIFO N
// -----------------------------------------------------------------------------
module demux1to2_buffered #(
  parameter int SIZE  = 16,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [SIZE-1:0]            in_data,
  input  logic                       in_switch,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [SIZE-1:0]            out1_data,
  output logic                       out1_valid,
  input  logic                       out1_ready,
  output logic [SIZE-1:0]            out2_data,
  output logic                       out2_valid,
  input  logic                       out2_ready,
  output logic [$clog2(DEPTH+1)-1:0] out1_count,
  output logic [$clog2(DEPTH+1)-1:0] out2_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Per-FIFO status gathered into small vectors, bit 0 = out1, bit 1 = out2.
  logic [1:0]           full;
  logic [1:0]           not_empty;
  logic [1:0]           pop_req;
  logic [1:0][SIZE-1:0] head;
  logic [1:0][CW-1:0]   level;

  assign pop_req = {out2_ready, out1_ready};

  // Ready depends only on the selected destination's occupancy, never on
  // in_valid or on the consumer accepting in the same cycle (no full-bypass).
  assign in_ready = in_switch ? ~full[1] : ~full[0];

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [SIZE-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;

    assign push = in_valid && (in_switch == 1'(g)) && !full[g];
    assign pop  = not_empty[g] && pop_req[g];

    // NOTE: the storage array has no reset; only pointers and count do. The
    // head is forced to zero while empty, so stale contents are never visible.
    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        // DEPTH is a power of two, so natural pointer overflow is the wrap.
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;  // idle, or push and pop cancel out
        endcase
      end
    end

    assign full[g]      = (count == CW'(DEPTH));
    assign not_empty[g] = (count != '0);
    assign head[g]      = not_empty[g] ? mem[rd_ptr] : '0;
    assign level[g]     = count;
  end

  assign out1_data  = head[0];
  assign out1_valid = not_empty[0];
  assign out1_count = level[0];
  assign out2_data  = head[1];
  assign out2_valid = not_empty[1];
  assign out2_count = level[1];

endmodule

// File: tb/tb_demux1to2_buffered.sv
// -----------------------------------------------------------------------------
// tb_demux1to2_buffered
//   Self-checking bench for demux1to2_buffered. The reference model is a pair
//   of queues holding the words each FIFO should contain. The driver appends
//   to a queue whenever the model says the input handshake will complete; a
//   separate monitor pops and compares on every output handshake. Directed
//   phases cover steering, fill/block, head stability, push/pop wrap,
//   full-no-bypass and asynchronous reset, followed by a random phase.
// -----------------------------------------------------------------------------
module tb_demux1to2_buffered;

  localparam int SIZE  = 16;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            reset_n;
  logic [SIZE-1:0] in_data;
  logic            in_switch;
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] out1_data;
  logic            out1_valid;
  logic            out1_ready;
  logic [SIZE-1:0] out2_data;
  logic            out2_valid;
  logic            out2_ready;
  logic [CW-1:0]   out1_count;
  logic [CW-1:0]   out2_count;

  demux1to2_buffered #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_switch  (in_switch),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out2_data  (out2_data),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready),
    .out1_count (out1_count),
    .out2_count (out2_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected contents of each FIFO, oldest first.
  logic [SIZE-1:0] q1[$];
  logic [SIZE-1:0] q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every completed output handshake must deliver the oldest
  // expected word of that FIFO.
  always @(posedge clk) begin
    if (reset_n) begin
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) check("out1 pop with empty model", 32'd1, 32'd0);
        else                check("out1_data at pop", 32'(out1_data), 32'(q1.pop_front()));
      end
      if (out2_valid && out2_ready) begin
        if (q2.size() == 0) check("out2 pop with empty model", 32'd1, 32'd0);
        else                check("out2_data at pop", 32'(out2_data), 32'(q2.pop_front()));
      end
    end
  end

  // Compare visible state against the model; called at a falling edge, when
  // the queues exactly reflect the DUT's FIFO contents.
  task automatic check_state();
    check("out1_count", 32'(out1_count), 32'(q1.size()));
    check("out2_count", 32'(out2_count), 32'(q2.size()));
    check("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
    check("out2_valid", 32'(out2_valid), 32'(q2.size() != 0));
    if (q1.size() != 0) check("out1_data head", 32'(out1_data), 32'(q1[0]));
    if (q2.size() != 0) check("out2_data head", 32'(out2_data), 32'(q2[0]));
  endtask

  // One clock of stimulus: check state, drive inputs, check in_ready and
  // record the word in the model if the handshake will complete.
  task automatic cycle(input logic [SIZE-1:0] d, input logic sw, input logic v,
                       input logic r1, input logic r2);
    bit exp_ready;
    @(negedge clk);
    check_state();
    in_data    = d;
    in_switch  = sw;
    in_valid   = v;
    out1_ready = r1;
    out2_ready = r2;
    #1;
    exp_ready = sw ? (q2.size() != DEPTH) : (q1.size() != DEPTH);
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    if (v && exp_ready) begin
      if (sw) q2.push_back(d);
      else    q1.push_back(d);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    in_data    = '0;
    in_switch  = 1'b0;
    in_valid   = 1'b0;
    out1_ready = 1'b0;
    out2_ready = 1'b0;
    #2;
    check("reset out1_valid", 32'(out1_valid), 32'd0);
    check("reset out2_valid", 32'(out2_valid), 32'd0);
    check("reset out1_data",  32'(out1_data),  32'd0);
    check("reset out2_data",  32'(out2_data),  32'd0);
    check("reset in_ready",   32'(in_ready),   32'd1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic steering with both consumers ready.
    cycle(16'hA5A5, 1'b0, 1'b1, 1'b1, 1'b1);
    cycle(16'h5A5A, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (3) cycle(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);

    // Fill FIFO1, then show FIFO2 still accepts.
    cycle(16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(16'h0002, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(16'h0009, 1'b0, 1'b1, 1'b0, 1'b0);   // blocked: FIFO1 full
    cycle(16'h0003, 1'b1, 1'b1, 1'b0, 1'b0);   // accepted into FIFO2
    cycle(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);   // head holds while not ready

    // Drain FIFO1 in order, then FIFO2.
    cycle(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Simultaneous push/pop across pointer wrap with one word resident.
    cycle(16'h00FF, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(16'h0010 + 16'(i), 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (2) cycle(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);

    // Full-no-bypass on FIFO2.
    cycle(16'h0021, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(16'h0022, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(16'h0023, 1'b1, 1'b1, 1'b0, 1'b1);   // full: refused despite pop
    cycle(16'h0023, 1'b1, 1'b1, 1'b0, 1'b0);   // accepted now
    cycle(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);   // count back to 2
    repeat (3) cycle(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset with FIFO1 holding two words.
    cycle(16'h0031, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(16'h0032, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset out1_valid", 32'(out1_valid), 32'd0);
    check("async reset out1_count", 32'(out1_count), 32'd0);
    check("async reset out1_data",  32'(out1_data),  32'd0);
    q1.delete();
    q2.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) cycle(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      cycle(16'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6));
    end

    // Drain and confirm the model agrees everything came out.
    repeat (4) cycle(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check_state();
    check("final q1 empty", 32'(q1.size()), 32'd0);
    check("final q2 empty", 32'(q2.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
